pdp_rdma_nan_filter: RTL and testbench



---
 rtl/pdp_rdma_nan_filter.sv | 224 ++++++++++++++++++++++
 tb/tb_pdp_rdma_nan_filter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp_rdma_nan_filter.sv
// pdp_rdma_nan_filter
// Sits between the PDP read DMA and the pooling core. For FP16 layers it
// can flush NaN elements to zero. It also counts NaN and Inf elements per
// layer and publishes both counts when the end-of-cube beat is accepted.
// Beats flow through a two-entry register slice (main + skid), and the
// ready toward the RDMA is registered.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rst   clock, synchronous active-high reset
//   reg2dp_op_load                    one-cycle layer start pulse
//   reg2dp_input_data                 0=INT8, 1=INT16, 2=FP16 (sampled at op_load)
//   reg2dp_nan_to_zero                NaN flush enable (sampled at op_load)
//   pdp_rdma2dp_valid/ready/pd        input beat stream (ready registered)
//   nan2dp_valid/ready/pd             filtered output beat stream
//   dp2reg_nan_input_num              NaN count of the last completed layer
//   dp2reg_inf_input_num              Inf count of the last completed layer
//   nan_layer_done                    one-cycle pulse when a layer completes
// CNT_INIT sets the value the running counters restart from at op_load.
// It stays 0 in silicon and only changes to preload the counters in simulation.
module pdp_rdma_nan_filter #(
    parameter int unsigned ELEM_NUM = 4,
    parameter int unsigned ELEM_W   = 16,
    parameter int unsigned PD_W     = 76,
    parameter logic [31:0] CNT_INIT = 32'h0
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rst,
    input  logic            reg2dp_op_load,
    input  logic [1:0]      reg2dp_input_data,
    input  logic            reg2dp_nan_to_zero,
    input  logic            pdp_rdma2dp_valid,
    output logic            pdp_rdma2dp_ready,
    input  logic [PD_W-1:0] pdp_rdma2dp_pd,
    output logic            nan2dp_valid,
    input  logic            nan2dp_ready,
    output logic [PD_W-1:0] nan2dp_pd,
    output logic [31:0]     dp2reg_nan_input_num,
    output logic [31:0]     dp2reg_inf_input_num,
    output logic            nan_layer_done
);

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned POP_W   = $clog2(ELEM_NUM + 1);
    localparam int unsigned EOC_BIT = 66;
    localparam logic [1:0]  FMT_FP16 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        fmt_q, fmt_d;
    logic              n2z_q, n2z_d;
    logic              idle_hold_q, idle_hold_d;
    logic              main_vld_q, main_vld_d;
    logic [PD_W-1:0]   main_pd_q, main_pd_d;
    logic              skid_vld_q, skid_vld_d;
    logic [PD_W-1:0]   skid_pd_q, skid_pd_d;
    logic              rdy_q, rdy_d;
    logic [CNT_W-1:0]  nan_cnt_q, nan_cnt_d;
    logic [CNT_W-1:0]  inf_cnt_q, inf_cnt_d;
    logic [CNT_W-1:0]  nan_out_q, nan_out_d;
    logic [CNT_W-1:0]  inf_out_q, inf_out_d;
    logic              done_q, done_d;

    logic [PD_W-1:0]   flt_pd;
    logic [POP_W-1:0]  nan_pop;
    logic [POP_W-1:0]  inf_pop;
    logic [ELEM_W-1:0] elem;
    logic              accept;
    logic              eoc;

    // Add a small per-beat count and clamp at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [POP_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    assign accept = rdy_q & pdp_rdma2dp_valid;
    assign eoc    = pdp_rdma2dp_pd[EOC_BIT];

    // Classify the incoming elements and build the flushed beat.
    always_comb begin
        flt_pd  = pdp_rdma2dp_pd;
        nan_pop = '0;
        inf_pop = '0;
        elem    = '0;
        for (int i = 0; i < int'(ELEM_NUM); i++) begin
            elem = pdp_rdma2dp_pd[i*ELEM_W +: ELEM_W];
            if (fmt_q == FMT_FP16 && elem[14:10] == 5'h1F) begin
                if (elem[9:0] != 10'h0) begin
                    nan_pop = nan_pop + POP_W'(1);
                    // Flush clears the sign too.
                    if (n2z_q) begin
                        flt_pd[i*ELEM_W +: ELEM_W] = '0;
                    end
                end else begin
                    inf_pop = inf_pop + POP_W'(1);
                end
            end
        end
    end

    // Register slice: the main entry drives the output and the skid entry
    // catches the beat accepted while the output stalls.
    always_comb begin
        main_vld_d = main_vld_q;
        main_pd_d  = main_pd_q;
        skid_vld_d = skid_vld_q;
        skid_pd_d  = skid_pd_q;

        if (main_vld_q && nan2dp_ready) begin
            main_vld_d = 1'b0;
        end
        if (skid_vld_q && !main_vld_d) begin
            main_vld_d = 1'b1;
            main_pd_d  = skid_pd_q;
            skid_vld_d = 1'b0;
        end
        if (accept) begin
            if (!main_vld_d) begin
                main_vld_d = 1'b1;
                main_pd_d  = flt_pd;
            end else begin
                skid_vld_d = 1'b1;
                skid_pd_d  = flt_pd;
            end
        end
    end

    // Layer FSM, counters and status outputs.
    always_comb begin
        state_d     = state_q;
        fmt_d       = fmt_q;
        n2z_d       = n2z_q;
        idle_hold_d = 1'b0;
        nan_cnt_d   = nan_cnt_q;
        inf_cnt_d   = inf_cnt_q;
        nan_out_d   = nan_out_q;
        inf_out_d   = inf_out_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The first IDLE cycle after a layer ignores op_load.
                if (reg2dp_op_load && !idle_hold_q) begin
                    state_d   = ST_RUN;
                    fmt_d     = reg2dp_input_data;
                    n2z_d     = reg2dp_nan_to_zero;
                    nan_cnt_d = CNT_INIT;
                    inf_cnt_d = CNT_INIT;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    nan_cnt_d = sat_add(nan_cnt_q, nan_pop);
                    inf_cnt_d = sat_add(inf_cnt_q, inf_pop);
                    if (eoc) begin
                        nan_out_d = nan_cnt_d;
                        inf_out_d = inf_cnt_d;
                        done_d    = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!main_vld_q && !skid_vld_q) begin
                    state_d     = ST_IDLE;
                    idle_hold_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is only offered in RUN and while the skid entry is free.
    assign rdy_d = (state_d == ST_RUN) && !skid_vld_d;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q     <= ST_IDLE;
            fmt_q       <= '0;
            n2z_q       <= 1'b0;
            idle_hold_q <= 1'b0;
            main_vld_q  <= 1'b0;
            main_pd_q   <= '0;
            skid_vld_q  <= 1'b0;
            skid_pd_q   <= '0;
            rdy_q       <= 1'b0;
            nan_cnt_q   <= '0;
            inf_cnt_q   <= '0;
            nan_out_q   <= '0;
            inf_out_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fmt_q       <= fmt_d;
            n2z_q       <= n2z_d;
            idle_hold_q <= idle_hold_d;
            main_vld_q  <= main_vld_d;
            main_pd_q   <= main_pd_d;
            skid_vld_q  <= skid_vld_d;
            skid_pd_q   <= skid_pd_d;
            rdy_q       <= rdy_d;
            nan_cnt_q   <= nan_cnt_d;
            inf_cnt_q   <= inf_cnt_d;
            nan_out_q   <= nan_out_d;
            inf_out_q   <= inf_out_d;
            done_q      <= done_d;
        end
    end

    assign pdp_rdma2dp_ready    = rdy_q;
    assign nan2dp_valid         = main_vld_q;
    assign nan2dp_pd            = main_pd_q;
    assign dp2reg_nan_input_num = nan_out_q;
    assign dp2reg_inf_input_num = inf_out_q;
    assign nan_layer_done       = done_q;

endmodule

// File: tb/tb_pdp_rdma_nan_filter.sv
// Testbench for pdp_rdma_nan_filter: a vector table of single-beat layers,
// directed multi-cycle sequences, and randomized layers checked against a
// queue-based reference model.
module tb_pdp_rdma_nan_filter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_load = 1'b0;
    logic [1:0]  in_fmt = 2'd0;
    logic        in_n2z = 1'b0;
    logic        in_valid = 1'b0;
    logic [75:0] in_pd = '0;
    logic        in_ready;
    logic        ds_ready = 1'b1;
    logic        out_valid;
    logic [75:0] out_pd;
    logic [31:0] nan_num, inf_num;
    logic        done;

    logic        s_in_ready, s_out_valid, s_done;
    logic [75:0] s_out_pd;
    logic [31:0] s_nan_num, s_inf_num;

    pdp_rdma_nan_filter dut (
        .nvdla_core_clk      (clk),
        .nvdla_core_rst      (rst),
        .reg2dp_op_load      (op_load),
        .reg2dp_input_data   (in_fmt),
        .reg2dp_nan_to_zero  (in_n2z),
        .pdp_rdma2dp_valid   (in_valid),
        .pdp_rdma2dp_ready   (in_ready),
        .pdp_rdma2dp_pd      (in_pd),
        .nan2dp_valid        (out_valid),
        .nan2dp_ready        (ds_ready),
        .nan2dp_pd           (out_pd),
        .dp2reg_nan_input_num(nan_num),
        .dp2reg_inf_input_num(inf_num),
        .nan_layer_done      (done)
    );

    // Second instance with counters preloaded near saturation.
    pdp_rdma_nan_filter #(.CNT_INIT(32'hFFFF_FFFE)) dut_sat (
        .nvdla_core_clk      (clk),
        .nvdla_core_rst      (rst),
        .reg2dp_op_load      (op_load),
        .reg2dp_input_data   (in_fmt),
        .reg2dp_nan_to_zero  (in_n2z),
        .pdp_rdma2dp_valid   (in_valid),
        .pdp_rdma2dp_ready   (s_in_ready),
        .pdp_rdma2dp_pd      (in_pd),
        .nan2dp_valid        (s_out_valid),
        .nan2dp_ready        (ds_ready),
        .nan2dp_pd           (s_out_pd),
        .dp2reg_nan_input_num(s_nan_num),
        .dp2reg_inf_input_num(s_inf_num),
        .nan_layer_done      (s_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [75:0] sb[$];
    logic [1:0]  m_fmt = 2'd0;
    logic        m_n2z = 1'b0;
    longint      m_nan = 0, m_inf = 0;
    bit          exp_done = 0;
    longint      exp_nan = 0, exp_inf = 0;
    int          done_cnt = 0, out_cnt = 0, in_stall_cnt = 0;

    function automatic logic [75:0] ref_beat(input logic [75:0] pd, input logic [1:0] fmt,
                                             input logic n2z, output int nn, output int ni);
        logic [75:0] r;
        r  = pd;
        nn = 0;
        ni = 0;
        for (int i = 0; i < 4; i++) begin
            int unsigned e, ex, mant;
            e    = 32'(pd[i*16 +: 16]);
            ex   = (e >> 10) % 32;
            mant = e % 1024;
            if (fmt == 2'd2 && ex == 31) begin
                if (mant != 0) begin
                    nn++;
                    if (n2z) r[i*16 +: 16] = 16'h0000;
                end else begin
                    ni++;
                end
            end
        end
        return r;
    endfunction

    function automatic longint sat32(input longint v);
        return (v > 64'sh0000_0000_FFFF_FFFF) ? 64'sh0000_0000_FFFF_FFFF : v;
    endfunction

    // Monitor: sampled on the falling edge, between driven updates.
    initial begin
        bit          stall_pend;
        logic [75:0] stall_pd;
        logic [75:0] e;
        int          nn, ni;
        stall_pend = 0;
        stall_pd   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                exp_done   = 0;
                stall_pend = 0;
            end else begin
                if (exp_done) begin
                    chk("done_pulse", 76'(done), 76'(1));
                    chk("nan_count", 76'(nan_num), 76'(exp_nan));
                    chk("inf_count", 76'(inf_num), 76'(exp_inf));
                    exp_done = 0;
                end else if (done) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_done: actual=1 required=0");
                end
                if (done) done_cnt++;
                if (stall_pend) begin
                    chk("stall_valid", 76'(out_valid), 76'(1));
                    chk("stall_pd", out_pd, stall_pd);
                end
                stall_pend = out_valid && !ds_ready;
                stall_pd   = out_pd;
                if (out_valid && ds_ready) begin
                    out_cnt++;
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: actual=%0h required=none", out_pd);
                    end else begin
                        e = sb.pop_front();
                        chk("out_beat", out_pd, e);
                    end
                end
                if (in_valid && !in_ready) in_stall_cnt++;
                if (in_valid && in_ready) begin
                    sb.push_back(ref_beat(in_pd, m_fmt, m_n2z, nn, ni));
                    m_nan = sat32(m_nan + longint'(nn));
                    m_inf = sat32(m_inf + longint'(ni));
                    if (in_pd[66]) begin
                        exp_done = 1;
                        exp_nan  = m_nan;
                        exp_inf  = m_inf;
                    end
                end
            end
        end
    end

    // Downstream ready: 0 always 1, 1 always 0, 2 pattern 1,0,0,1, 3 random.
    int       ds_mode = 0;
    int       bp_idx  = 0;
    logic [3:0] bp_pat = 4'b1001;
    initial forever begin
        @(posedge clk);
        #2;
        case (ds_mode)
            0: ds_ready = 1'b1;
            1: ds_ready = 1'b0;
            2: begin
                ds_ready = bp_pat[bp_idx];
                bp_idx   = (bp_idx + 1) % 4;
            end
            default: ds_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic start_layer(input logic [1:0] fmt, input logic n2z);
        in_fmt  = fmt;
        in_n2z  = n2z;
        m_fmt   = fmt;
        m_n2z   = n2z;
        m_nan   = 0;
        m_inf   = 0;
        op_load = 1'b1;
        @(posedge clk); #1;
        op_load = 1'b0;
        // Mid-layer config changes must not matter.
        in_fmt  = 2'($urandom_range(0, 3));
        in_n2z  = ~n2z;
    endtask

    task automatic send_beat(input logic [75:0] pd);
        bit got;
        got      = 0;
        in_valid = 1'b1;
        in_pd    = pd;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) got = 1;
            @(posedge clk); #1;
            if (got) break;
        end
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", 76'(0), 76'(1));
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid && !exp_done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 76'(0), 76'(1));
        repeat (4) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_elem();
        logic [15:0] e;
        e = 16'($urandom);
        case ($urandom_range(0, 3))
            0: e[14:10] = 5'h1F;
            1: begin
                e[14:10] = 5'h1F;
                e[9:0]   = 10'h0;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [75:0] rand_beat(input bit last);
        logic [75:0] b;
        b = {12'($urandom), rand_elem(), rand_elem(), rand_elem(), rand_elem()};
        b[66] = last;
        return b;
    endfunction

    typedef struct {
        logic [1:0]  fmt;
        logic        n2z;
        logic [63:0] din;
        logic [63:0] dout;
        int          nan;
        int          inf;
    } vec_t;

    initial begin
        vec_t        vt[7];
        logic [11:0] hi;
        int          d0, o0, s0;

        vt[0] = '{2'd2, 1'b1, 64'hFFFF_3C00_FC00_7E01, 64'h0000_3C00_FC00_0000, 2, 1};
        vt[1] = '{2'd2, 1'b0, 64'hFFFF_3C00_FC00_7E01, 64'hFFFF_3C00_FC00_7E01, 2, 1};
        vt[2] = '{2'd0, 1'b1, 64'hFFFF_3C00_FC00_7E01, 64'hFFFF_3C00_FC00_7E01, 0, 0};
        vt[3] = '{2'd1, 1'b1, 64'h7C00_7BFF_FC01_7C01, 64'h7C00_7BFF_FC01_7C01, 0, 0};
        vt[4] = '{2'd2, 1'b1, 64'h7C00_7BFF_FC01_7C01, 64'h7C00_7BFF_0000_0000, 2, 1};
        vt[5] = '{2'd2, 1'b1, 64'hFC00_7C00_FC00_7C00, 64'hFC00_7C00_FC00_7C00, 0, 4};
        vt[6] = '{2'd2, 1'b1, 64'h8000_0000_03FF_FFC0, 64'h8000_0000_03FF_0000, 1, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 76'(out_valid), 76'(0));
        chk("rst_in_ready", 76'(in_ready), 76'(0));
        chk("rst_out_pd", out_pd, 76'(0));
        chk("rst_nan", 76'(nan_num), 76'(0));
        chk("rst_inf", 76'(inf_num), 76'(0));
        chk("rst_done", 76'(done), 76'(0));
        @(posedge clk); #1;

        // Table: single-beat layers, downstream always ready
        for (int v = 0; v < 7; v++) begin
            hi = 12'($urandom) | 12'h004;
            d0 = done_cnt;
            start_layer(vt[v].fmt, vt[v].n2z);
            send_beat({hi, vt[v].din});
            @(negedge clk);
            chk("tbl_valid_latency", 76'(out_valid), 76'(1));
            chk("tbl_out_pd", out_pd, {hi, vt[v].dout});
            chk("tbl_done", 76'(done), 76'(1));
            chk("tbl_nan", 76'(nan_num), 76'(vt[v].nan));
            chk("tbl_inf", 76'(inf_num), 76'(vt[v].inf));
            @(posedge clk); #1;
            wait_drain();
            chk("tbl_done_once", 76'(done_cnt - d0), 76'(1));
        end

        // INT8 layer, 8 beats of all-FF
        d0 = done_cnt;
        start_layer(2'd0, 1'b1);
        for (int b = 0; b < 8; b++) begin
            logic [75:0] p;
            p = {76{1'b1}};
            p[66] = (b == 7);
            send_beat(p);
        end
        wait_drain();
        chk("int8_nan", 76'(nan_num), 76'(0));
        chk("int8_inf", 76'(inf_num), 76'(0));
        chk("int8_done_once", 76'(done_cnt - d0), 76'(1));

        // Backpressure with ready pattern 1,0,0,1
        ds_mode = 2;
        @(posedge clk); #1;
        d0 = done_cnt; o0 = out_cnt; s0 = in_stall_cnt;
        start_layer(2'd2, 1'b1);
        for (int b = 0; b < 6; b++) send_beat(rand_beat(b == 5));
        wait_drain();
        chk("bp_out_count", 76'(out_cnt - o0), 76'(6));
        chk("bp_ready_dropped", 76'(in_stall_cnt > s0), 76'(1));
        chk("bp_done_once", 76'(done_cnt - d0), 76'(1));
        ds_mode = 0;
        @(posedge clk); #1;

        // Saturation: preloaded instance must clamp at FFFF_FFFF
        start_layer(2'd2, 1'b1);
        send_beat({12'h000, 64'h7E00_7E00_7E00_7E00});
        send_beat({12'h004, 64'h7C00_7C00_7E00_7E00});
        wait_drain();
        chk("sat_nan", 76'(s_nan_num), 76'(32'hFFFF_FFFF));
        chk("sat_inf", 76'(s_inf_num), 76'(32'hFFFF_FFFF));
        chk("unsat_nan", 76'(nan_num), 76'(6));
        chk("unsat_inf", 76'(inf_num), 76'(2));

        // Reset with two beats buffered
        ds_mode = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        d0 = done_cnt;
        start_layer(2'd2, 1'b1);
        send_beat({12'h000, 64'h7E01_3C00_3C00_3C00});
        send_beat({12'h000, 64'hFC00_7E01_3C00_3C00});
        in_valid = 1'b1;
        in_pd    = {12'h004, 64'h1234_5678_9ABC_DEF0};
        @(negedge clk);
        chk("two_stored_ready_low", 76'(in_ready), 76'(0));
        chk("two_stored_valid", 76'(out_valid), 76'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 76'(out_valid), 76'(0));
        chk("midrst_in_ready", 76'(in_ready), 76'(0));
        chk("midrst_out_pd", out_pd, 76'(0));
        chk("midrst_nan", 76'(nan_num), 76'(0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_idle_ready", 76'(in_ready), 76'(0));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("midrst_no_done", 76'(done_cnt - d0), 76'(0));
        ds_mode = 0;
        @(posedge clk); #1;
        d0 = done_cnt;
        start_layer(2'd2, 1'b1);
        send_beat({12'h004, 64'h3C00_3C00_3C00_3C00});
        wait_drain();
        chk("post_rst_nan", 76'(nan_num), 76'(0));
        chk("post_rst_inf", 76'(inf_num), 76'(0));
        chk("post_rst_done_once", 76'(done_cnt - d0), 76'(1));

        // Randomized layers with random downstream ready
        ds_mode = 3;
        for (int l = 0; l < 6; l++) begin
            int nb;
            nb = $urandom_range(3, 10);
            d0 = done_cnt;
            start_layer(($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1)) : 2'd2,
                        1'($urandom_range(0, 1)));
            for (int b = 0; b < nb; b++) send_beat(rand_beat(b == nb - 1));
            wait_drain();
            chk("rand_done_once", 76'(done_cnt - d0), 76'(1));
        end
        ds_mode = 0;

        chk("scoreboard_empty", 76'(sb.size()), 76'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
